picomips_program_counter: RTL and testbench
===========================================

Name: picomips_program_counter

Overview:
- Program counter for the picoMIPS core.
- Holds the current instruction address driven to program memory.
- Per clock it can hold, increment by one, take a PC-relative branch or take an absolute jump.
- Sits between the decoder/control unit and the program ROM address input.

Parameters:
- program_code_size, 5, width in bits of the program address (PC wraps modulo 2**program_code_size).
- offset_size, 5, width of the signed relative-branch offset (two's complement, sign-extended to program_code_size).
- STACK_DEPTH, 4, entries in the optional return-address stack (used only with PC_STACK_EN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_reset  input  1  asynchronous active-low reset.
- pc_inc  input  1  advance PC by one this cycle.
- pc_branch  input  1  relative branch: PC <= PC + 1 + sext(branch_offset).
- branch_offset  input  offset_size  signed branch offset.
- pc_jump  input  1  absolute jump: PC <= jump_addr.
- jump_addr  input  program_code_size  absolute target address.
- pc_out  output  program_code_size  current PC (registered, drives ROM address).
- pc_next  output  program_code_size  combinational value PC will take at the next edge.
- pc_wrap  output  1  registered, high for one cycle after PC wrapped from all-ones to 0 via increment.

Behaviour:
- n_reset low: pc_out=0, pc_wrap=0 immediately (asynchronous, no clock needed); stack pointer=0 when the stack is built in.
- Reset has priority over everything, including mid-count; counting resumes from 0 on the first rising edge after n_reset deasserts with pc_inc high.
- Update priority at each rising edge (highest first): pc_jump > pc_branch > pc_inc > hold.
- Command effects:
  - Hold: pc_out unchanged.
  - pc_inc: pc_out <= pc_out + 1.
  - pc_branch: target = pc_out + 1 + sign-extended branch_offset.
  - pc_jump: pc_out <= jump_addr.
- Arithmetic: all results truncated to program_code_size bits (modulo wrap, no saturation, no error).
- pc_wrap: set for exactly one cycle when an increment takes pc_out from 2**N-1 to 0; branch or jump wrap does not assert pc_wrap.
- pc_next always equals the value pc_out will hold after the next edge, given the current inputs (reset excepted).
- Latency: one clock from command to pc_out change; no pipelining.
- Asserting several commands simultaneously is legal; the priority order resolves it.
- X on command inputs during reset is ignored.

Optional Feature:
- Macro PC_STACK_EN.
- When defined, adds:
  - inputs pc_call and pc_ret (1 bit each);
  - outputs stack_overflow and stack_underflow (1 bit each, registered sticky, cleared only by reset);
  - a STACK_DEPTH-entry LIFO of program_code_size-bit return addresses.
- pc_call: pushes pc_out+1, then PC <= jump_addr.
- pc_ret: pops, PC <= popped value.
- Priority with the stack built in: pc_ret > pc_call > pc_jump > pc_branch > pc_inc.
- Push when full: PC still jumps, the push is dropped and stack_overflow is set.
- Pop when empty: PC holds and stack_underflow is set.
- When undefined: none of these ports or state exist; behaviour is exactly as above.

Test Plan:
- Reset at t=1ns between edges -> pc_out=0 with no clock edge; hold with pc_inc=0 for one edge -> stays 0.
- pc_inc=1 for 24 rising edges from 0 -> pc_out=24; assert n_reset low mid-cycle -> pc_out=0 asynchronously; release and count 3 edges -> 3; drop pc_inc -> holds 3.
- N=5, count from 30 -> 31, then 0 with pc_wrap=1 for one cycle, then 1 with pc_wrap=0.
- pc_out=10, pc_branch=1 with offset -4 -> pc_out=7; offset +5 -> 13; from 30 with offset +3 -> 2 (wrap), pc_wrap stays 0.
- pc_jump=1, jump_addr=17, with pc_branch and pc_inc also high -> pc_out=17; pc_next shows 17 before the edge.
- (PC_STACK_EN) call at PC=3 to 20, then ret -> PC=4; ret on empty stack -> PC holds, stack_underflow=1; 5 nested calls -> stack_overflow=1.

Source files
------------

// File: rtl/picomips_program_counter.sv
// picoMIPS program counter: hold / increment / PC-relative branch / absolute jump.
// Optional return-address stack (call/ret) is built in when PC_STACK_EN is defined.
module picomips_program_counter #(
  parameter int program_code_size = 5,
  parameter int offset_size       = 5,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         pc_inc,
  input  logic                         pc_branch,
  input  logic [offset_size-1:0]       branch_offset,
  input  logic                         pc_jump,
  input  logic [program_code_size-1:0] jump_addr,
`ifdef PC_STACK_EN
  input  logic                         pc_call,
  input  logic                         pc_ret,
  output logic                         stack_overflow,
  output logic                         stack_underflow,
`endif
  output logic [program_code_size-1:0] pc_out,
  output logic [program_code_size-1:0] pc_next,
  output logic                         pc_wrap
);

  localparam logic [program_code_size-1:0] PC_ONE = program_code_size'(1);

  logic [program_code_size-1:0]        r_pc;
  logic                                r_wrap;
  logic [program_code_size-1:0]        w_next;
  logic                                w_wrap_next;
  logic [program_code_size-1:0]        w_inc_val;
  logic [program_code_size-1:0]        w_branch_val;
  logic signed [offset_size-1:0]       w_off_s;
  logic signed [program_code_size-1:0] w_off_ext;

  assign w_off_s      = branch_offset;
  assign w_off_ext    = w_off_s;  // signed assignment sign-extends the offset
  assign w_inc_val    = r_pc + PC_ONE;
  assign w_branch_val = w_inc_val + w_off_ext;

`ifdef PC_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [program_code_size-1:0] r_stack [STACK_DEPTH];
  logic [SPW-1:0]               r_sp;
  logic                         r_ovf;
  logic                         r_unf;
  logic [SPW-1:0]               w_sp_next;
  logic [SPW-1:0]               w_sp_dec;
  logic                         w_push;
  logic                         w_ovf_set;
  logic                         w_unf_set;

  assign w_sp_dec        = r_sp - SP_ONE;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;
`endif

  always_comb begin
    w_next      = r_pc;
    w_wrap_next = 1'b0;
`ifdef PC_STACK_EN
    w_sp_next   = r_sp;
    w_push      = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (pc_ret) begin
      if (r_sp == '0) begin
        w_unf_set = 1'b1;
      end else begin
        w_next    = r_stack[w_sp_dec[AW-1:0]];
        w_sp_next = w_sp_dec;
      end
    end else if (pc_call) begin
      // A full stack still takes the jump; only the push is lost.
      w_next = jump_addr;
      if (r_sp == SP_FULL) begin
        w_ovf_set = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_sp_next = r_sp + SP_ONE;
      end
    end else
`endif
    if (pc_jump) begin
      w_next = jump_addr;
    end else if (pc_branch) begin
      w_next = w_branch_val;
    end else if (pc_inc) begin
      w_next      = w_inc_val;
      w_wrap_next = (r_pc == '1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pc   <= '0;
      r_wrap <= 1'b0;
`ifdef PC_STACK_EN
      r_sp   <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
`endif
    end else begin
      r_pc   <= w_next;
      r_wrap <= w_wrap_next;
`ifdef PC_STACK_EN
      r_sp   <= w_sp_next;
      r_ovf  <= r_ovf | w_ovf_set;
      r_unf  <= r_unf | w_unf_set;
`endif
    end
  end

`ifdef PC_STACK_EN
  // Stack contents need no reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (n_reset && w_push) begin
      r_stack[r_sp[AW-1:0]] <= w_inc_val;
    end
  end
`endif

  assign pc_out  = r_pc;
  assign pc_next = w_next;
  assign pc_wrap = r_wrap;

endmodule

// File: tb/tb_picomips_program_counter.sv
// Directed self-checking bench for picomips_program_counter (N=5, offset 5 bits).
module tb_picomips_program_counter;

  localparam int N = 5;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          pc_inc;
  logic          pc_branch;
  logic [OW-1:0] branch_offset;
  logic          pc_jump;
  logic [N-1:0]  jump_addr;
  logic [N-1:0]  pc_out;
  logic [N-1:0]  pc_next;
  logic          pc_wrap;
`ifdef PC_STACK_EN
  logic          pc_call;
  logic          pc_ret;
  logic          stack_overflow;
  logic          stack_underflow;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  picomips_program_counter #(
    .program_code_size(N),
    .offset_size(OW),
    .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .pc_inc(pc_inc),
    .pc_branch(pc_branch),
    .branch_offset(branch_offset),
    .pc_jump(pc_jump),
    .jump_addr(jump_addr),
`ifdef PC_STACK_EN
    .pc_call(pc_call),
    .pc_ret(pc_ret),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow),
`endif
    .pc_out(pc_out),
    .pc_next(pc_next),
    .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b1; pc_inc = 1'b0; pc_branch = 1'b0; pc_jump = 1'b0;
    branch_offset = '0; jump_addr = '0;
`ifdef PC_STACK_EN
    pc_call = 1'b0; pc_ret = 1'b0;
`endif
    #1 n_reset = 1'b0;
    #1;
    check("async_reset_pc", 8'(pc_out), 8'd0);
    check("async_reset_wrap", 8'(pc_wrap), 8'd0);
    step();
    n_reset = 1'b1;
    step();
    check("hold_after_reset", 8'(pc_out), 8'd0);
    check("hold_pc_next", 8'(pc_next), 8'd0);

    pc_inc = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      $display("inc edge %0d pc_out=%0d", i, pc_out);
      check("count", 8'(pc_out), 8'(i));
    end
    #2 n_reset = 1'b0;
    #1;
    check("midcount_reset", 8'(pc_out), 8'd0);
    #1 n_reset = 1'b1;
    step(); step(); step();
    check("count_after_reset", 8'(pc_out), 8'd3);
    pc_inc = 1'b0;
    step();
    check("hold_3", 8'(pc_out), 8'd3);

    pc_jump = 1'b1; jump_addr = 5'd30;
    step();
    check("jump_30", 8'(pc_out), 8'd30);
    pc_jump = 1'b0; pc_inc = 1'b1;
    step();
    check("inc_31", 8'(pc_out), 8'd31);
    check("wrap_low_at_31", 8'(pc_wrap), 8'd0);
    check("pc_next_wrap", 8'(pc_next), 8'd0);
    step();
    check("wrap_to_0", 8'(pc_out), 8'd0);
    check("wrap_pulse", 8'(pc_wrap), 8'd1);
    step();
    check("after_wrap_1", 8'(pc_out), 8'd1);
    check("wrap_cleared", 8'(pc_wrap), 8'd0);
    $display("wrap sequence done pc_out=%0d", pc_out);

    pc_inc = 1'b0; pc_jump = 1'b1; jump_addr = 5'd10;
    step();
    pc_jump = 1'b0; pc_branch = 1'b1; branch_offset = 5'b11100;
    #1;
    check("pc_next_branch_m4", 8'(pc_next), 8'd7);
    step();
    check("branch_m4", 8'(pc_out), 8'd7);
    branch_offset = 5'd5;
    step();
    check("branch_p5", 8'(pc_out), 8'd13);
    pc_branch = 1'b0; pc_jump = 1'b1; jump_addr = 5'd30;
    step();
    pc_jump = 1'b0; pc_branch = 1'b1; branch_offset = 5'd3;
    step();
    check("branch_wrap", 8'(pc_out), 8'd2);
    check("branch_wrap_nopulse", 8'(pc_wrap), 8'd0);
    pc_branch = 1'b0; pc_jump = 1'b1; jump_addr = 5'd31;
    step();
    pc_jump = 1'b0; pc_branch = 1'b1; pc_inc = 1'b1; branch_offset = 5'd0;
    step();
    check("branch_31_to_0", 8'(pc_out), 8'd0);
    check("branch_over_inc_nopulse", 8'(pc_wrap), 8'd0);

    pc_jump = 1'b1; jump_addr = 5'd17; branch_offset = 5'd6;
    #1;
    check("pc_next_jump_prio", 8'(pc_next), 8'd17);
    step();
    check("jump_prio", 8'(pc_out), 8'd17);
    pc_jump = 1'b0; branch_offset = 5'd2;
    step();
    check("branch_over_inc", 8'(pc_out), 8'd20);
    pc_branch = 1'b0; pc_inc = 1'b0;
    step();
    check("hold_20", 8'(pc_out), 8'd20);
    $display("priority checks done pc_out=%0d", pc_out);

`ifdef PC_STACK_EN
    pc_jump = 1'b1; jump_addr = 5'd3;
    step();
    pc_jump = 1'b0; pc_call = 1'b1; jump_addr = 5'd20;
    step();
    check("call_target", 8'(pc_out), 8'd20);
    pc_call = 1'b0; pc_ret = 1'b1;
    step();
    check("ret_addr", 8'(pc_out), 8'd4);
    step();
    check("ret_empty_hold", 8'(pc_out), 8'd4);
    check("underflow", 8'(stack_underflow), 8'd1);
    pc_ret = 1'b0; pc_call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      jump_addr = 5'(i + 8);
      step();
      $display("call %0d pc_out=%0d ovf=%0d", i, pc_out, stack_overflow);
      check("nested_call_pc", 8'(pc_out), 8'(i + 8));
      if (i == 4) check("no_overflow_at_4", 8'(stack_overflow), 8'd0);
    end
    check("overflow", 8'(stack_overflow), 8'd1);
    pc_call = 1'b0; pc_ret = 1'b1;
    step();
    check("ret_after_overflow", 8'(pc_out), 8'd12);
    pc_ret = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
